// File: rtl/mem_responder.sv
// Fetch/data request arbiter in front of a single-port 16-bit word RAM.
// Define MEM_INIT_EN to preload the RAM image; otherwise it starts zeroed.
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [15:0] d_rdata
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                w_resp;

    logic                w_d_acc;
    logic                w_i_acc;
    logic                w_acc;
    logic [ADDR_W-1:0]   w_addr;
    logic [15:0]         w_rd;
    logic [15:0]         w_acc_data;

    logic                r_pend_i;
    logic [15:0]         r_pend_data;
    logic                w_resp_i;
    logic [15:0]         w_resp_data;

    logic                r_i_rvalid;
    logic                r_d_rvalid;
    logic [15:0]         r_i_rdata;
    logic [15:0]         r_d_rdata;

    logic                w_unused;

`ifdef MEM_INIT_EN
    logic [15:0] r_mem [DEPTH] = '{0: 16'hA001, default: 16'h0000};
`else
    logic [15:0] r_mem [DEPTH] = '{default: 16'h0000};
`endif

    // Upper address bits are dropped so addresses wrap modulo the depth
    assign w_unused = ^{i_addr[15:ADDR_W], d_addr[15:ADDR_W]};

    assign d_ready = (r_state == S_IDLE);
    assign i_ready = (r_state == S_IDLE) && !d_req;

    assign w_d_acc = d_ready && d_req;
    assign w_i_acc = i_ready && i_req;
    assign w_acc   = w_d_acc || w_i_acc;

    assign w_addr = w_d_acc ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
    assign w_rd   = r_mem[w_addr];

    // Write acknowledges return zero data
    assign w_acc_data = (w_d_acc && d_we) ? 16'h0000 : w_rd;

    always_ff @(posedge clk) begin
        if (w_d_acc && d_we) begin
            r_mem[w_addr] <= d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_resp      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (WS == 4'd0) begin
                        w_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = WS;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_resp      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Zero wait states respond straight from the accept; else from the capture
    assign w_resp_i    = (WS == 4'd0) ? w_i_acc : r_pend_i;
    assign w_resp_data = (WS == 4'd0) ? w_acc_data : r_pend_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_i    <= 1'b0;
            r_pend_data <= 16'h0000;
            r_i_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_i_rdata   <= 16'h0000;
            r_d_rdata   <= 16'h0000;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            if (w_acc) begin
                r_pend_i    <= w_i_acc;
                r_pend_data <= w_acc_data;
            end
            if (w_resp) begin
                if (w_resp_i) begin
                    r_i_rvalid <= 1'b1;
                    r_i_rdata  <= w_resp_data;
                end else begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= w_resp_data;
                end
            end
        end
    end

    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: zero-wait and three-wait instances
// share clock and reset; vectors hold inputs and next-sampled outputs.
module tb_mem_responder;

    typedef struct {
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwdata;
        logic        eir;
        logic        edr;
        logic        eirv;
        logic        edrv;
        logic [15:0] eird;
        logic [15:0] edrd;
    } vec_t;

`ifdef MEM_INIT_EN
    localparam logic [15:0] INIT0 = 16'hA001;
`else
    localparam logic [15:0] INIT0 = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;

    logic        i_req0, i_ready0, i_rvalid0;
    logic [15:0] i_addr0, i_rdata0;
    logic        d_req0, d_we0, d_ready0, d_rvalid0;
    logic [15:0] d_addr0, d_wdata0, d_rdata0;

    logic        i_req3, i_ready3, i_rvalid3;
    logic [15:0] i_addr3, i_rdata3;
    logic        d_req3, d_we3, d_ready3, d_rvalid3;
    logic [15:0] d_addr3, d_wdata3, d_rdata3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req0),
        .i_addr  (i_addr0),
        .i_ready (i_ready0),
        .i_rvalid(i_rvalid0),
        .i_rdata (i_rdata0),
        .d_req   (d_req0),
        .d_we    (d_we0),
        .d_addr  (d_addr0),
        .d_wdata (d_wdata0),
        .d_ready (d_ready0),
        .d_rvalid(d_rvalid0),
        .d_rdata (d_rdata0)
    );

    mem_responder #(.ADDR_W(10), .WAIT_STATES(3)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req3),
        .i_addr  (i_addr3),
        .i_ready (i_ready3),
        .i_rvalid(i_rvalid3),
        .i_rdata (i_rdata3),
        .d_req   (d_req3),
        .d_we    (d_we3),
        .d_addr  (d_addr3),
        .d_wdata (d_wdata3),
        .d_ready (d_ready3),
        .d_rvalid(d_rvalid3),
        .d_rdata (d_rdata3)
    );

    function automatic vec_t mk(
        input logic        ireq,
        input logic [15:0] iaddr,
        input logic        dreq,
        input logic        dwe,
        input logic [15:0] daddr,
        input logic [15:0] dwdata,
        input logic        eir,
        input logic        edr,
        input logic        eirv,
        input logic        edrv,
        input logic [15:0] eird,
        input logic [15:0] edrd
    );
        vec_t v;
        v.ireq = ireq;  v.iaddr = iaddr;
        v.dreq = dreq;  v.dwe = dwe;
        v.daddr = daddr; v.dwdata = dwdata;
        v.eir = eir;    v.edr = edr;
        v.eirv = eirv;  v.edrv = edrv;
        v.eird = eird;  v.edrd = edrd;
        return v;
    endfunction

    task automatic check(
        input string       nm,
        input logic [35:0] act,
        input logic [35:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, then sample
    // {i_ready,d_ready,i_rvalid,d_rvalid,i_rdata,d_rdata}
    task automatic run_vec(input int sel, input vec_t v, input string nm);
        logic [35:0] act;
        logic [35:0] exp;
        @(negedge clk);
        if (sel == 0) begin
            i_req0 = v.ireq;  i_addr0 = v.iaddr;
            d_req0 = v.dreq;  d_we0 = v.dwe;
            d_addr0 = v.daddr; d_wdata0 = v.dwdata;
        end else begin
            i_req3 = v.ireq;  i_addr3 = v.iaddr;
            d_req3 = v.dreq;  d_we3 = v.dwe;
            d_addr3 = v.daddr; d_wdata3 = v.dwdata;
        end
        #1;
        if (sel == 0)
            act = {i_ready0, d_ready0, i_rvalid0, d_rvalid0,
                   i_rdata0, d_rdata0};
        else
            act = {i_ready3, d_ready3, i_rvalid3, d_rvalid3,
                   i_rdata3, d_rdata3};
        exp = {v.eir, v.edr, v.eirv, v.edrv, v.eird, v.edrd};
        check(nm, act, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t t0[12];
        vec_t t3[13];
        vec_t z;
        logic bad;

        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        t0[0]  = mk(1, 16'h0000, 0, 0, 0, 0,
                    1, 1, 0, 0, 16'h0000, 16'h0000);
        t0[1]  = mk(0, 0, 1, 1, 16'h0005, 16'hBEEF,
                    0, 1, 1, 0, INIT0, 16'h0000);
        t0[2]  = mk(0, 0, 1, 0, 16'h0005, 0,
                    0, 1, 0, 1, INIT0, 16'h0000);
        t0[3]  = mk(0, 0, 1, 1, 16'h0010, 16'h1111,
                    0, 1, 0, 1, INIT0, 16'hBEEF);
        t0[4]  = mk(0, 0, 1, 1, 16'h0020, 16'h2222,
                    0, 1, 0, 1, INIT0, 16'h0000);
        t0[5]  = mk(0, 0, 1, 1, 16'h0403, 16'h1234,
                    0, 1, 0, 1, INIT0, 16'h0000);
        t0[6]  = mk(1, 16'h0010, 1, 0, 16'h0020, 0,
                    0, 1, 0, 1, INIT0, 16'h0000);
        t0[7]  = mk(1, 16'h0010, 0, 0, 0, 0,
                    1, 1, 0, 1, INIT0, 16'h2222);
        t0[8]  = mk(0, 0, 1, 0, 16'h0003, 0,
                    0, 1, 1, 0, 16'h1111, 16'h2222);
        t0[9]  = mk(0, 0, 0, 0, 0, 0,
                    1, 1, 0, 1, 16'h1111, 16'h1234);
        t0[10] = mk(1, 16'h0405, 0, 0, 0, 0,
                    1, 1, 0, 0, 16'h1111, 16'h1234);
        t0[11] = mk(0, 0, 0, 0, 0, 0,
                    1, 1, 1, 0, 16'hBEEF, 16'h1234);

        t3[0]  = mk(0, 0, 1, 1, 16'h0009, 16'h5A5A,
                    0, 1, 0, 0, 16'h0000, 16'h0000);
        t3[1]  = z;
        t3[2]  = z;
        t3[3]  = z;
        t3[4]  = mk(1, 16'h0009, 0, 0, 0, 0,
                    1, 1, 0, 1, 16'h0000, 16'h0000);
        t3[5]  = z;
        t3[6]  = z;
        t3[7]  = z;
        t3[8]  = mk(0, 0, 1, 0, 16'h0409, 0,
                    0, 1, 1, 0, 16'h5A5A, 16'h0000);
        t3[9]  = mk(0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 16'h5A5A, 16'h0000);
        t3[10] = t3[9];
        t3[11] = t3[9];
        t3[12] = mk(0, 0, 0, 0, 0, 0,
                    1, 1, 0, 1, 16'h5A5A, 16'h5A5A);

        rst_n = 1'b0;
        i_req0 = 0; i_addr0 = 0; d_req0 = 0;
        d_we0 = 0;  d_addr0 = 0; d_wdata0 = 0;
        i_req3 = 0; i_addr3 = 0; d_req3 = 0;
        d_we3 = 0;  d_addr3 = 0; d_wdata3 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++)
            run_vec(0, t0[k], $sformatf("ws0_v%0d", k));
        for (int k = 0; k < 13; k++)
            run_vec(3, t3[k], $sformatf("ws3_v%0d", k));

        // Reset in the middle of a three-wait read
        run_vec(3, mk(0, 0, 1, 0, 16'h0009, 0,
                      0, 1, 0, 0, 16'h5A5A, 16'h5A5A), "rst_acc");
        run_vec(3, mk(0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0, 16'h5A5A, 16'h5A5A), "rst_wait");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async",
              {i_ready3, d_ready3, i_rvalid3, d_rvalid3,
               i_rdata3, d_rdata3},
              {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            bad = bad | i_rvalid3 | d_rvalid3;
        end
        check("rst_no_stale_rvalid", {35'd0, bad}, 36'd0);

        run_vec(3, mk(0, 0, 1, 0, 16'h0009, 0,
                      0, 1, 0, 0, 16'h0000, 16'h0000), "rst_reread");
        for (int k = 0; k < 3; k++)
            run_vec(3, z, $sformatf("rst_wait_%0d", k));
        run_vec(3, mk(0, 0, 0, 0, 0, 0,
                      1, 1, 0, 1, 16'h0000, 16'h5A5A), "rst_kept");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
